// File: rtl/ext_pkg.sv
// ext_pkg: shared types and helpers for the extension stage.
// Mode encodings, width legality check and offset width helper.
package ext_pkg;

  typedef enum logic [2:0] {
    EXT_SIGN_IMM = 3'd0,
    EXT_ZERO_IMM = 3'd1,
    EXT_LUI      = 3'd2,
    EXT_LB       = 3'd3,
    EXT_LBU      = 3'd4,
    EXT_LH       = 3'd5,
    EXT_LHU      = 3'd6,
    EXT_WORD     = 3'd7
  } ext_mode_e;

  localparam int EXT_DATA_W_DEF = 32;
  localparam int EXT_LUI_SHIFT  = 16;

  // Only 32- and 64-bit datapaths are supported.
  function automatic bit data_w_ok(input int w);
    return (w == 32) || (w == 64);
  endfunction

  // Byte-offset width for a datapath of w bits.
  function automatic int off_w(input int w);
    return $clog2(w / 8);
  endfunction

endpackage

// File: rtl/ext_core.sv
// ext_core: combinational immediate / load-data extender.
// Produces the extended result and the misalign flag.
module ext_core
  import ext_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int IMM_W  = 16,
  localparam int OFF_W  = off_w(DATA_W)
) (
  input  ext_mode_e         i_mode,
  input  logic [DATA_W-1:0] i_data,
  input  logic [OFF_W-1:0]  i_off,
  output logic [DATA_W-1:0] o_res,
  output logic              o_mis
);

  logic [IMM_W-1:0]  w_imm;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_lui32;
  logic [DATA_W-1:0] w_lui;
  logic [OFF_W+2:0]  w_bidx;
  logic [OFF_W+2:0]  w_hidx;

  assign w_imm   = i_data[IMM_W-1:0];
  assign w_bidx  = {i_off, 3'b000};
  assign w_hidx  = {i_off[OFF_W-1:1], 4'b0000};
  assign w_byte  = i_data[w_bidx +: 8];
  assign w_half  = i_data[w_hidx +: 16];
  assign w_lui32 = 32'({w_imm, 16'h0000});
  // 64-bit lui sign-extends from bit 31
  assign w_lui   = DATA_W'($signed(w_lui32));

  // Mode decode: every encoding is defined
  always_comb begin
    o_res = '0;
    o_mis = 1'b0;
    case (i_mode)
      EXT_SIGN_IMM: o_res = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
      EXT_ZERO_IMM: o_res = DATA_W'(w_imm);
      EXT_LUI:      o_res = w_lui;
      EXT_LB:       o_res = {{(DATA_W-8){w_byte[7]}}, w_byte};
      EXT_LBU:      o_res = DATA_W'(w_byte);
      EXT_LH: begin
        o_res = {{(DATA_W-16){w_half[15]}}, w_half};
        o_mis = i_off[0];
      end
      EXT_LHU: begin
        o_res = DATA_W'(w_half);
        o_mis = i_off[0];
      end
      EXT_WORD: begin
        o_res = i_data;
        o_mis = (i_off != '0);
      end
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: registered extension stage with a 2-entry skid buffer.
// O is the output register, S absorbs one cycle of downstream stall.
module ext_pipe
  import ext_pkg::*;
#(
  parameter  int DATA_W = EXT_DATA_W_DEF,
  parameter  int IMM_W  = 16,
  parameter  int TAG_W  = 5,
  localparam int OFF_W  = off_w(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_misalign
);

  if (!data_w_ok(DATA_W)) begin : g_bad_w
    $error("ext_pipe: DATA_W must be 32 or 64");
  end

  logic              r_o_valid;
  logic [DATA_W-1:0] r_o_data;
  logic [TAG_W-1:0]  r_o_tag;
  logic              r_o_mis;

  logic              r_s_valid;
  logic [DATA_W-1:0] r_s_data;
  logic [TAG_W-1:0]  r_s_tag;
  logic              r_s_mis;

  logic [DATA_W-1:0] w_res;
  logic              w_mis;
  logic              w_in_xfer;
  logic              w_o_load;
  logic              w_s_load;
  logic              w_s_drain;

  ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_core (
    .i_mode (ext_mode_e'(in_mode)),
    .i_data (in_data),
    .i_off  (in_offset),
    .o_res  (w_res),
    .o_mis  (w_mis)
  );

  assign in_ready  = !r_s_valid;
  assign w_in_xfer = in_valid && in_ready;
  assign w_o_load  = !r_o_valid || out_ready;
  assign w_s_drain = w_o_load && r_s_valid;
  assign w_s_load  = w_in_xfer && r_o_valid
                  && (!out_ready || r_s_valid);

  // Output register: takes S first, else the new input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_o_valid <= 1'b0;
      r_o_data  <= '0;
      r_o_tag   <= '0;
      r_o_mis   <= 1'b0;
    end else if (flush) begin
      r_o_valid <= 1'b0;
    end else if (w_o_load) begin
      if (r_s_valid) begin
        r_o_valid <= 1'b1;
        r_o_data  <= r_s_data;
        r_o_tag   <= r_s_tag;
        r_o_mis   <= r_s_mis;
      end else begin
        r_o_valid <= w_in_xfer;
        if (w_in_xfer) begin
          r_o_data <= w_res;
          r_o_tag  <= in_tag;
          r_o_mis  <= w_mis;
        end
      end
    end
  end

  // Skid register: catches an input when O cannot take it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s_valid <= 1'b0;
      r_s_data  <= '0;
      r_s_tag   <= '0;
      r_s_mis   <= 1'b0;
    end else if (flush) begin
      r_s_valid <= 1'b0;
    end else begin
      r_s_valid <= w_s_load || (r_s_valid && !w_s_drain);
      if (w_s_load) begin
        r_s_data <= w_res;
        r_s_tag  <= in_tag;
        r_s_mis  <= w_mis;
      end
    end
  end

  assign out_valid    = r_o_valid;
  assign out_data     = r_o_data;
  assign out_tag      = r_o_tag;
  assign out_misalign = r_o_mis;

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: directed checks for ext_pipe (32- and 64-bit).
// Expected values are hand-computed constants.
module tb_ext_pipe;
  import ext_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;

  logic        in_valid, in_ready, out_valid, out_ready, out_mis;
  logic [2:0]  in_mode;
  logic [31:0] in_data, out_data;
  logic [1:0]  in_offset;
  logic [4:0]  in_tag, out_tag;

  logic        q_in_valid, q_in_ready, q_out_valid, q_out_ready, q_out_mis;
  logic [2:0]  q_in_mode;
  logic [63:0] q_in_data, q_out_data;
  logic [2:0]  q_in_offset;
  logic [4:0]  q_in_tag, q_out_tag;

  int n_chk;
  int n_err;

  ext_pipe #(.DATA_W(32)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mode      (in_mode),
    .in_data      (in_data),
    .in_offset    (in_offset),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_tag      (out_tag),
    .out_misalign (out_mis)
  );

  ext_pipe #(.DATA_W(64)) dut64 (
    .clk          (clk),
    .reset        (rst_n),
    .flush        (flush),
    .in_valid     (q_in_valid),
    .in_ready     (q_in_ready),
    .in_mode      (q_in_mode),
    .in_data      (q_in_data),
    .in_offset    (q_in_offset),
    .in_tag       (q_in_tag),
    .out_valid    (q_out_valid),
    .out_ready    (q_out_ready),
    .out_data     (q_out_data),
    .out_tag      (q_out_tag),
    .out_misalign (q_out_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string      tag,
                      input logic [2:0]  m,
                      input logic [31:0] d,
                      input logic [1:0]  off,
                      input logic [4:0]  t,
                      input logic [31:0] ed,
                      input logic        em);
    in_valid  = 1'b1;
    in_mode   = m;
    in_data   = d;
    in_offset = off;
    in_tag    = t;
    step();
    in_valid = 1'b0;
    chk({tag, "_v"}, out_valid, 1'b1);
    chk({tag, "_d"}, out_data, ed);
    chk({tag, "_t"}, out_tag, t);
    chk({tag, "_m"}, out_mis, em);
  endtask

  task automatic send64(input string      tag,
                        input logic [2:0]  m,
                        input logic [63:0] d,
                        input logic [2:0]  off,
                        input logic [63:0] ed,
                        input logic        em);
    q_in_valid  = 1'b1;
    q_in_mode   = m;
    q_in_data   = d;
    q_in_offset = off;
    q_in_tag    = 5'd9;
    step();
    q_in_valid = 1'b0;
    chk({tag, "_v"}, q_out_valid, 1'b1);
    chk({tag, "_d"}, q_out_data, ed);
    chk({tag, "_m"}, q_out_mis, em);
  endtask

  initial begin
    int   got;
    int   nt;
    int   stall;
    bit   saw_low;

    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_mode = 3'd0;
    in_data = '0;
    in_offset = '0;
    in_tag = '0;
    out_ready = 1'b1;
    q_in_valid = 1'b0;
    q_in_mode = 3'd0;
    q_in_data = '0;
    q_in_offset = '0;
    q_in_tag = '0;
    q_out_ready = 1'b1;

    // reset state, inputs ignored while held
    in_valid = 1'b1;
    repeat (2) step();
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_ir", in_ready, 1'b1);
    chk("rst_od", out_data, 32'h0);
    chk("rst_ot", out_tag, 5'h0);
    chk("rst_om", out_mis, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // immediates (offset ignored)
    send("sx",  EXT_SIGN_IMM, 32'h0000_8001, 2'd3, 5'd1,
         32'hFFFF_8001, 1'b0);
    send("zx",  EXT_ZERO_IMM, 32'h0000_8001, 2'd3, 5'd2,
         32'h0000_8001, 1'b0);
    send("lui", EXT_LUI, 32'h0000_1234, 2'd1, 5'd3,
         32'h1234_0000, 1'b0);
    send("lui2", EXT_LUI, 32'hFFFF_8000, 2'd2, 5'd4,
         32'h8000_0000, 1'b0);

    // loads
    send("lb3",  EXT_LB,  32'h80FF_7F01, 2'd3, 5'd5,
         32'hFFFF_FF80, 1'b0);
    send("lbu1", EXT_LBU, 32'h80FF_7F01, 2'd1, 5'd6,
         32'h0000_007F, 1'b0);
    send("lh2",  EXT_LH,  32'h80FF_7F01, 2'd2, 5'd7,
         32'hFFFF_80FF, 1'b0);
    send("lhu3", EXT_LHU, 32'h80FF_7F01, 2'd3, 5'd8,
         32'h0000_80FF, 1'b1);
    send("lh1",  EXT_LH,  32'h80FF_7F01, 2'd1, 5'd9,
         32'h0000_7F01, 1'b1);
    send("wd1",  EXT_WORD, 32'h80FF_7F01, 2'd1, 5'd10,
         32'h80FF_7F01, 1'b1);
    send("wd0",  EXT_WORD, 32'h1357_9BDF, 2'd0, 5'd11,
         32'h1357_9BDF, 1'b0);
    step();
    chk("drain_ov", out_valid, 1'b0);

    // backpressure: tags 1..6, stall 3 cycles after tag 2
    got = 0;
    nt = 1;
    stall = 0;
    saw_low = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      out_ready = (stall == 0);
      in_valid  = (nt <= 6);
      in_mode   = EXT_WORD;
      in_offset = 2'd0;
      in_data   = 32'hA500_0000 | 32'(nt);
      in_tag    = 5'(nt);
      if (!in_ready) saw_low = 1'b1;
      if (out_valid && out_ready) begin
        chk("bp_tag", out_tag, 64'(got + 1));
        chk("bp_data", out_data, 64'(32'hA500_0000 | 32'(got + 1)));
        got++;
      end
      if (stall > 0) stall--;
      if (in_valid && in_ready) begin
        if (nt == 2) stall = 3;
        nt++;
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 64'(got), 64'd6);
    chk("bp_ir_low", 64'(saw_low), 64'd1);
    step();
    chk("bp_nodup", out_valid, 1'b0);

    // flush with both entries full and input pending
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_mode = EXT_WORD;
    in_offset = 2'd0;
    in_data = 32'h0000_0011;
    in_tag = 5'h11;
    step();
    in_data = 32'h0000_0012;
    in_tag = 5'h12;
    step();
    chk("fl_full_ir", in_ready, 1'b0);
    chk("fl_full_ov", out_valid, 1'b1);
    in_data = 32'h0000_0013;
    in_tag = 5'h13;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_ov", out_valid, 1'b0);
    chk("fl_ir", in_ready, 1'b1);
    out_ready = 1'b1;
    step();
    chk("fl_gone1", out_valid, 1'b0);
    step();
    chk("fl_gone2", out_valid, 1'b0);

    // async reset mid-stall with both entries full
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_mode = EXT_LUI;
    in_data = 32'h0000_ABCD;
    in_tag = 5'h15;
    step();
    in_tag = 5'h16;
    step();
    in_valid = 1'b0;
    chk("rm_full_ov", out_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rm_ov", out_valid, 1'b0);
    chk("rm_od", out_data, 32'h0);
    chk("rm_ir", in_ready, 1'b1);
    chk("rm_ot", out_tag, 5'h0);
    #2;
    rst_n = 1'b1;
    step();
    chk("rm_after_ov", out_valid, 1'b0);
    out_ready = 1'b1;
    send("rm_new", EXT_SIGN_IMM, 32'h0000_7FFF, 2'd0, 5'd20,
         32'h0000_7FFF, 1'b0);
    step();

    // 64-bit datapath
    send64("q_lb7", EXT_LB, 64'h8001_0203_0405_0607, 3'd7,
           64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    send64("q_wd4", EXT_WORD, 64'h8001_0203_0405_0607, 3'd4,
           64'h8001_0203_0405_0607, 1'b1);
    send64("q_lui", EXT_LUI, 64'h0000_0000_0000_8000, 3'd0,
           64'hFFFF_FFFF_8000_0000, 1'b0);
    send64("q_lhu6", EXT_LHU, 64'h8001_0203_0405_0607, 3'd6,
           64'h0000_0000_0000_8001, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ext_pipe.md
# ext_pipe

Registered, parametrised extension stage for the pipelined datapath. It performs two kinds of extension:

- **Immediates:** sign, zero and lui.
- **Load data:** lb/lbu/lh/lhu/word selection with sign or zero extension.

It sits between MEM and WB, and is shared by the immediate path. A valid/ready handshake with a 2-entry skid buffer lets it absorb one cycle of downstream stall without losing data.

## Interface
- DATA_W, 32: datapath width. Legal values are 32 and 64. OFF_W = $clog2(DATA_W/8).
- IMM_W, 16: immediate width, taken from in_data[IMM_W-1:0].
- TAG_W, 5: sideband tag carried with the data (e.g. destination register).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops all held and incoming entries.
- in_valid  in  1  input entry present.
- in_ready  out  1  stage can accept an entry this cycle.
- in_mode  in  3  extension mode (encodings under Operation).
- in_data  in  DATA_W  raw word or immediate.
- in_offset  in  OFF_W  byte address offset for load modes.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  extended result.
- out_tag  out  TAG_W  tag travelling with the result.
- out_misalign  out  1  the access was misaligned.

## Operation
- Mode encodings:
  - 0 SIGN_IMM, 1 ZERO_IMM, 2 LUI: in_offset is ignored and misalign = 0.
  - 3 LB, 4 LBU, 5 LH, 6 LHU, 7 WORD.
- SIGN_IMM sign-extends imm to DATA_W. ZERO_IMM zero-extends it.
- LUI produces imm << 16, zero-filled, truncated to DATA_W. With DATA_W=64 it is sign-extended from bit 31, matching MIPS64 lui.
- LB/LBU select byte in_data[8*off +: 8], then sign- or zero-extend it.
- LH/LHU select half in_data[16*off[OFF_W-1:1] +: 16], i.e. bit 0 of the offset is forced to 0. Then sign- or zero-extend.
  - misalign = off[0].
- WORD passes in_data unchanged. misalign = (off != 0).
- Every mode is defined, so there is no default output value.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Storage consists of an output register (O) and a skid register (S), each with its own valid bit.
- in_ready = !S.valid. It is registered-derived and has no combinational path from out_ready.
- Per-edge update, when flush = 0:
  - O empty, or O transferring out:
    - If S is valid, S moves to O.
    - Otherwise the input, if any, moves to O.
    - If S moved to O and an input also arrives, the input moves to S.
  - O valid and not transferring out, with an input arriving: the input goes to S. This is only possible while S is empty.
- Values are extended before storage. Both O and S hold finished results, tag and misalign.
- flush = 1: both valid bits clear on the next edge. An input accepted in the same cycle is discarded. in_ready still reflects pre-flush S.
- Data contents of empty entries are don't-care but are never X after reset.

## Timing
- Latency is 1 cycle from input transfer to out_valid when O is empty or draining.
- Throughput is 1 entry per cycle while out_ready stays high.
- Reset (asserted, asynchronous) forces: out_valid = 0, S.valid = 0, in_ready = 1, out_data = 0, out_tag = 0, out_misalign = 0.
- While reset is asserted, inputs are ignored.
- Reset asserted mid-stall drops both entries immediately. No handshake is required on release.
- out_ready low with both entries full: in_ready = 0. The upstream must hold its entry.
- With both entries full and out_ready rising: O takes S at the edge, and in_ready = 1 in the following cycle.
- Ordering is strictly FIFO. No entry is duplicated or skipped.

## Structure
- Package ext_pkg holds:
  - the mode enum and encodings above;
  - the DATA_W legality check;
  - the OFF_W helper function.
- Sub-module ext_core is purely combinational: mode, data and offset in; result and misalign out. It is instantiated once at the input. ext_pipe itself holds only the O/S registers and the handshake logic.

## Test plan
- **Immediates:** SIGN_IMM in_data=0x0000_8001 → 0xFFFF_8001. ZERO_IMM → 0x0000_8001. LUI imm=0x1234 → 0x1234_0000. All with misalign = 0 and 1-cycle latency.
- **Loads:** in_data=0x80FF_7F01.
  - LB off=3 → 0xFFFF_FF80. LBU off=1 → 0x0000_007F.
  - LH off=2 → 0xFFFF_80FF. LHU off=3 → 0x0000_80FF with misalign = 1.
  - WORD off=1 → 0x80FF_7F01 with misalign = 1.
- **Backpressure:** stream tags 1..6 back-to-back; hold out_ready low for 3 cycles after tag 2.
  - Required: in_ready drops once S fills.
  - Output order is 1..6 with no loss or duplication.
- **Flush:** with both entries full and in_valid high, pulse flush.
  - Required: next cycle out_valid = 0 and in_ready = 1; the flushed input never appears.
- **Reset mid-operation:** assert reset asynchronously between edges while full.
  - Required: out_valid = 0 and out_data = 0 immediately.
  - After release, the first new entry emerges 1 cycle after it is accepted.
- **DATA_W=64:** LB off=7 on 0x80.. (top byte) → all-ones upper bits. WORD off=4 → misalign = 1.
